// File: rtl/audio_sample_scheduler.sv
// Buffers 12-bit SPI audio samples in a small FIFO and serves them to an I2S transmitter on request.
// Optional macro SCHED_UNDERRUN_COUNT_EN adds a saturating 8-bit underrun_count output.
module audio_sample_scheduler #(
  parameter int          DEPTH   = 8,
  parameter int          PREFILL = 4,
  parameter logic [11:0] SILENCE = 12'd2048
) (
  input  logic                     s_clk,
  input  logic                     reset,
  input  logic [11:0]              sample_in,
  input  logic                     sample_valid,
  input  logic                     sample_req,
  output logic [11:0]              sample_out,
  output logic                     streaming,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic                     underrun
`ifdef SCHED_UNDERRUN_COUNT_EN
  ,
  output logic [7:0]               underrun_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LEVEL_FULL    = LW'(DEPTH);
  localparam logic [LW-1:0] LEVEL_PREFILL = LW'(PREFILL);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_STREAM  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [11:0]     sample_out_q, sample_out_d;
  logic            overflow_q, overflow_d;
  logic            underrun_q, underrun_d;

  logic [11:0]     mem_q [DEPTH];

  logic            fifo_full;
  logic            fifo_empty;
  logic            in_stream;
  logic            push;
  logic            pop;

  assign fifo_full  = (level_q == LEVEL_FULL);
  assign fifo_empty = (level_q == '0);
  assign in_stream  = (state_q == ST_STREAM);

  // A pop frees a slot in the same cycle, so a write to a full FIFO is only
  // refused when no pop accompanies it.
  assign pop  = sample_req && in_stream && !fifo_empty;
  assign push = sample_valid && (!fifo_full || pop);

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    sample_out_d = sample_out_q;
    overflow_d   = 1'b0;
    underrun_d   = 1'b0;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    if (sample_valid && !push) begin
      overflow_d = 1'b1;
    end

    // An empty FIFO yields silence even if a write lands in the same cycle.
    if (sample_req) begin
      if (pop) begin
        sample_out_d = mem_q[rd_ptr_q];
      end else begin
        sample_out_d = SILENCE;
      end
      if (in_stream && fifo_empty) begin
        underrun_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (push) begin
          state_d = ST_PREFILL;
        end
      end
      ST_PREFILL: begin
        if (level_q >= LEVEL_PREFILL) begin
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (sample_req && fifo_empty) begin
          state_d = ST_PREFILL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge s_clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      sample_out_q <= SILENCE;
      overflow_q   <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      sample_out_q <= sample_out_d;
      overflow_q   <= overflow_d;
      underrun_q   <= underrun_d;
    end
  end

  // Sample storage carries no reset so it maps onto block RAM.
  always_ff @(posedge s_clk) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= sample_in;
    end
  end

`ifdef SCHED_UNDERRUN_COUNT_EN
  logic [7:0] underrun_count_q, underrun_count_d;

  always_comb begin
    underrun_count_d = underrun_count_q;
    if (underrun_d && (underrun_count_q != 8'hFF)) begin
      underrun_count_d = underrun_count_q + 8'd1;
    end
  end

  always_ff @(posedge s_clk) begin
    if (reset) begin
      underrun_count_q <= '0;
    end else begin
      underrun_count_q <= underrun_count_d;
    end
  end

  assign underrun_count = underrun_count_q;
`endif

  assign sample_out = sample_out_q;
  assign streaming  = in_stream;
  assign fifo_level = level_q;
  assign overflow   = overflow_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Scoreboard bench for audio_sample_scheduler: stimulus queues expected responses, a monitor compares them.
module tb_audio_sample_scheduler;

  logic        s_clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        sample_req = 1'b0;
  logic [11:0] sample_out;
  logic        streaming;
  logic [3:0]  fifo_level;
  logic        overflow;
  logic        underrun;
`ifdef SCHED_UNDERRUN_COUNT_EN
  logic [7:0]  underrun_count;
`endif

  audio_sample_scheduler dut (
    .s_clk        (s_clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_req   (sample_req),
    .sample_out   (sample_out),
    .streaming    (streaming),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .underrun     (underrun)
`ifdef SCHED_UNDERRUN_COUNT_EN
    ,
    .underrun_count (underrun_count)
`endif
  );

  always #5 s_clk = ~s_clk;

  typedef struct {
    string       tag;
    logic        chk_out;
    logic [11:0] out;
    logic        ur;
    logic        ov;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Monitor: every non-reset cycle with a write or request owes one scoreboard entry.
  always @(posedge s_clk) begin
    logic had, rst;
    exp_t e;
    had = sample_valid || sample_req;
    rst = reset;
    #1;
    if (!rst) begin
      if (had) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_empty: got transaction, expected none queued");
        end else begin
          e = exp_q.pop_front();
          if (e.chk_out) check({e.tag, ".out"}, sample_out, e.out);
          check({e.tag, ".underrun"}, underrun, e.ur);
          check({e.tag, ".overflow"}, overflow, e.ov);
        end
      end else begin
        if (underrun !== 1'b0 || overflow !== 1'b0)
          check("idle_pulses", {underrun, overflow}, 0);
      end
    end
  end

  task automatic drive(input string tag, input logic v, input logic [11:0] d, input logic r,
                       input logic chk, input logic [11:0] eo, input logic eu, input logic eov);
    exp_t e;
    @(negedge s_clk);
    sample_valid = v;
    sample_in    = d;
    sample_req   = r;
    e.tag = tag; e.chk_out = chk; e.out = eo; e.ur = eu; e.ov = eov;
    exp_q.push_back(e);
    @(posedge s_clk);
    #1;
    sample_valid = 1'b0;
    sample_req   = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [11:0] d, input logic eov);
    drive(tag, 1'b1, d, 1'b0, 1'b0, 12'h000, 1'b0, eov);
  endtask

  task automatic rq(input string tag, input logic [11:0] eo, input logic eu);
    drive(tag, 1'b0, 12'h000, 1'b1, 1'b1, eo, eu, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge s_clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge s_clk);
    #1;
    check("rst.sample_out", sample_out, 12'd2048);
    check("rst.streaming", streaming, 0);
    check("rst.level", fifo_level, 0);
    check("rst.overflow", overflow, 0);
    check("rst.underrun", underrun, 0);
    @(negedge s_clk);
    reset = 1'b0;

    // Requests with no data give silence and stay idle
    for (int i = 0; i < 3; i++) rq("idle_req", 12'd2048, 1'b0);
    check("idle.streaming", streaming, 0);
    check("idle.level", fifo_level, 0);

    // Prefill then stream four samples in order
    wr("w100", 12'h100, 1'b0);
    wr("w200", 12'h200, 1'b0);
    wr("w300", 12'h300, 1'b0);
    wr("w400", 12'h400, 1'b0);
    check("prefill.level", fifo_level, 4);
    idle(1);
    check("prefill.streaming", streaming, 1);
    rq("r100", 12'h100, 1'b0);
    rq("r200", 12'h200, 1'b0);
    rq("r300", 12'h300, 1'b0);
    rq("r400", 12'h400, 1'b0);
    check("drain.level", fifo_level, 0);
    idle(3);
    check("hold.sample_out", sample_out, 12'h400);

    // Underrun on empty FIFO
    rq("underrun1", 12'd2048, 1'b1);
    check("underrun1.streaming", streaming, 0);
`ifdef SCHED_UNDERRUN_COUNT_EN
    check("underrun1.count", underrun_count, 1);
`endif

    // Fill to full, ninth write is dropped
    for (int i = 1; i <= 8; i++) wr($sformatf("fill%0d", i), 12'hA00 + 12'(i), 1'b0);
    wr("fill9_drop", 12'hA09, 1'b1);
    check("full.level", fifo_level, 8);
    check("full.streaming", streaming, 1);

    // Write and request together on a full FIFO
    drive("full_wr_rq", 1'b1, 12'hB00, 1'b1, 1'b1, 12'hA01, 1'b0, 1'b0);
    check("full_wr_rq.level", fifo_level, 8);

    // Drain: dropped A09 must not appear, B00 follows A08
    for (int i = 2; i <= 8; i++) rq($sformatf("rA0%0d", i), 12'hA00 + 12'(i), 1'b0);
    rq("rB00", 12'hB00, 1'b0);
    check("drain2.level", fifo_level, 0);

    // Mid-stream reset with level 5; inputs during reset are ignored
    for (int i = 1; i <= 5; i++) wr($sformatf("d%0d", i), 12'hD00 + 12'(i), 1'b0);
    check("pre_rst.level", fifo_level, 5);
    check("pre_rst.streaming", streaming, 1);
    @(negedge s_clk);
    reset = 1'b1; sample_valid = 1'b1; sample_req = 1'b1; sample_in = 12'hFFF;
    @(posedge s_clk);
    #1;
    reset = 1'b0; sample_valid = 1'b0; sample_req = 1'b0;
    check("mid_rst.level", fifo_level, 0);
    check("mid_rst.sample_out", sample_out, 12'd2048);
    check("mid_rst.streaming", streaming, 0);
`ifdef SCHED_UNDERRUN_COUNT_EN
    check("mid_rst.count", underrun_count, 0);
`endif
    rq("post_rst_req", 12'd2048, 1'b0);
    check("post_rst.level", fifo_level, 0);

    // Write and request together on an empty streaming FIFO is an underrun
    for (int i = 1; i <= 4; i++) wr($sformatf("e%0d", i), 12'hE00 + 12'(i), 1'b0);
    idle(1);
    check("e.streaming", streaming, 1);
    for (int i = 1; i <= 4; i++) rq($sformatf("rE0%0d", i), 12'hE00 + 12'(i), 1'b0);
    drive("empty_wr_rq", 1'b1, 12'hE05, 1'b1, 1'b1, 12'd2048, 1'b1, 1'b0);
    check("empty_wr_rq.level", fifo_level, 1);
    check("empty_wr_rq.streaming", streaming, 0);
`ifdef SCHED_UNDERRUN_COUNT_EN
    check("empty_wr_rq.count", underrun_count, 1);
`endif

    idle(2);
    check("scoreboard_leftover", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/audio_sample_scheduler.md
AUDIO_SAMPLE_SCHEDULER -- requirements
Module: audio_sample_scheduler

Interface
REQ-001 Parameter DEPTH SHALL default to 8; FIFO depth in samples, power of two, range 4..16.
REQ-002 Parameter PREFILL SHALL default to 4; fill level required before streaming, range 1..DEPTH.
REQ-003 Parameter SILENCE SHALL default to 12'd2048; mid-scale word issued whenever no real sample is available.
REQ-004 Port s_clk SHALL be input, 1 bit; the single clock; all state updates on its rising edge.
REQ-005 Port reset SHALL be input, 1 bit; synchronous, active-high.
REQ-006 Port sample_in SHALL be input, 12 bits; unsigned offset-binary sample from the SPI receiver.
REQ-007 Port sample_valid SHALL be input, 1 bit; one-cycle pulse marking sample_in valid.
REQ-008 Port sample_req SHALL be input, 1 bit; one-cycle pulse from the I2S transmitter requesting the next word.
REQ-009 Port sample_out SHALL be output, 12 bits; registered word presented to the I2S transmitter.
REQ-010 Port streaming SHALL be output, 1 bit; high while in state STREAM.
REQ-011 Port fifo_level SHALL be output, $clog2(DEPTH)+1 bits; current occupancy.
REQ-012 Port overflow SHALL be output, 1 bit; one-cycle pulse when an incoming sample is dropped.
REQ-013 Port underrun SHALL be output, 1 bit; one-cycle pulse when STREAM finds the FIFO empty on a request.

Function
REQ-014 States SHALL be IDLE, PREFILL and STREAM, one-hot or binary at implementer's choice.
REQ-015 IDLE SHALL go to PREFILL on the first accepted write; PREFILL SHALL go to STREAM the cycle after fifo_level reaches PREFILL.
REQ-016 On sample_valid with FIFO not full, sample_in SHALL be written and level incremented.
REQ-017 On sample_valid with FIFO full and no simultaneous pop, the sample SHALL be dropped, level unchanged, overflow pulsed the following cycle.
REQ-018 On sample_req in STREAM with FIFO not empty, sample_out SHALL load the oldest sample one cycle later and the entry SHALL be popped.
REQ-019 On sample_req in STREAM with FIFO empty, sample_out SHALL load SILENCE, underrun SHALL pulse, and state SHALL go to PREFILL.
REQ-020 On sample_req in IDLE or PREFILL, sample_out SHALL load SILENCE and the FIFO SHALL not be popped.
REQ-021 Simultaneous write and pop SHALL both take effect; level unchanged; no overflow even when full.
REQ-022 Simultaneous write and request on an empty FIFO in STREAM SHALL count as underrun; no write-through bypass.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH or go below 0.
REQ-024 sample_out SHALL hold its value between requests.

Reset
REQ-025 While reset is high at a clock edge: state IDLE, pointers and level 0, sample_out SILENCE, streaming 0, overflow 0, underrun 0.
REQ-026 Reset asserted mid-stream SHALL discard all buffered samples; sample_valid and sample_req are ignored during that cycle.

Configuration
REQ-027 With macro SCHED_UNDERRUN_COUNT_EN defined, output underrun_count (8 bits) SHALL increment on each underrun pulse, saturate at 255, and clear on reset.
REQ-028 Without SCHED_UNDERRUN_COUNT_EN, the underrun_count port and its counter SHALL not exist; all other behaviour is identical.

Verification
REQ-029 Reset, then sample_req pulses with no writes -> sample_out = 2048, streaming = 0, state IDLE.
REQ-030 Write 0x100,0x200,0x300,0x400 -> streaming = 1 the cycle after the fourth write; four requests -> sample_out 0x100..0x400 in order, each one cycle after its request.
REQ-031 Fifth request on empty FIFO -> sample_out = 2048, underrun pulses once, streaming = 0, underrun_count = 1 when macro defined.
REQ-032 Nine writes with no requests -> fifo_level = 8, overflow pulses once, ninth sample absent from subsequent reads.
REQ-033 Full FIFO with write and request in the same cycle -> level stays 8, no overflow, oldest sample output.
REQ-034 Reset asserted with level 5 in STREAM -> next cycle level 0, sample_out 2048, streaming 0.
